ice_echo_slave: RTL
===================

// Module: ice_echo_slave
// PURPOSE
//  Bus-side responder for the ice master frame bus. Captures master frames whose ma_addr matches ADDR into a local buffer.
//  Arbitrates for the slave output bus and returns the frame to ice_bus_controller for UART transmission to the host.
//  Used as the loopback/diagnostic device for the host-to-FPGA-to-host path; occupies one sl_arb_request/sl_arb_grant slot.
// PARAMETERS
//  ADDR        8'h65  master frame type handled (echoed back as the response type)
//  DEPTH_LOG2  6      log2 of payload buffer depth in bytes (64)
// PORTS
//  clk             in   1  system clock
//  reset           in   1  synchronous, active-high reset
//  ma_data         in   8  master payload byte
//  ma_addr         in   8  master frame type, stable while ma_frame_valid
//  ma_data_valid   in   1  one-cycle strobe: ma_data holds a new byte
//  ma_frame_valid  in   1  high for whole frame; falling edge = frame end
//  sl_overflow     out  1  one-cycle pulse: byte of a matching frame dropped, buffer full
//  sl_addr         out  9  response type {1'b0,ADDR} while granted, else 0
//  sl_data         out  9  {last,byte} while granted, else 0
//  sl_tail         out  9  {1'b1,status} while sl_latch_tail, else 0
//  sl_latch_tail   out  1  one-cycle tail strobe
//  sl_arb_request  out  1  response pending
//  sl_arb_grant    in   1  high = byte on sl_data consumed this cycle
//  global_counter  in   8  event counter (ECHO_TIMESTAMP_EN only)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, buffer count 0. Reset mid-frame or mid-send discards everything.
//    No request after reset until a new matching frame completes.
//  Output bus: sl_* are OR-combined at the top level, so every sl_* output is 0 whenever not driving.
//  FSM states:
//    IDLE: on ma_frame_valid rise go to RECV if ma_addr==ADDR, else go to DROP.
//      A strobe coinciding with the rise is captured.
//    RECV: each ma_data_valid writes ma_data at wr_ptr and increments the count.
//      At count==2**DEPTH_LOG2: byte discarded, sl_overflow pulses, ovf flag set.
//      On ma_frame_valid fall: zero bytes -> IDLE (no response), else -> REQ.
//    DROP: ignore until ma_frame_valid falls -> IDLE.
//    REQ: sl_arb_request=1. Drives the first byte combinationally: sl_addr/sl_data valid in the same cycle the grant arrives.
//    SEND: each grant cycle pops one byte; rd_ptr increments and the next byte is presented on the next cycle.
//      sl_data[8]=1 on the final byte. sl_arb_request stays high through the final granted byte.
//      The cycle after the final grant: -> TAIL.
//    TAIL: one cycle; sl_latch_tail=1, sl_tail={1'b1,ovf,count[6:0]}. -> IDLE, count/ptrs/ovf cleared.
//    Grant low mid-send: hold the current byte, no pop (stall of any length allowed).
//  Frames arriving while in REQ/SEND/TAIL: ignored entirely, no overflow pulse. Single-frame buffer.
//  Latency: frame end -> sl_arb_request high in 1 cycle. TAIL follows the last grant by 1 cycle.
//  Count is DEPTH_LOG2+1 bits, saturating at depth; pointers wrap modulo depth.
// CONFIGURATION
//  ECHO_TIMESTAMP_EN defined:
//    global_counter is sampled at frame start and sent as the first response byte, ahead of the payload.
//    Total sent = count+1. The last flag moves accordingly.
//  ECHO_TIMESTAMP_EN undefined:
//    global_counter is unused and the response is the payload only.
// STRUCTURE
//  Shared package/include (include/ice_def.v): state encodings, the SL_LAST bit index, and a tail status field layout macro.
//  Sub-module: ice_echo_buf, a simple dual-port byte RAM with DEPTH_LOG2 address bits, registered write, async read.
//    FSM and pointers stay in ice_echo_slave.
// TESTING
//  1. Frame ADDR, bytes 01 02 03, grant held high:
//     -> sl_data 001,002,103 on consecutive cycles; tail 103 (1'b1,ovf=0,count=3); request drops after the last byte.
//  2. Frame type 8'h41 with 4 bytes -> no request, no overflow, DROP then IDLE.
//  3. 70-byte matching frame (depth 64):
//     -> 6 sl_overflow pulses; 64 bytes echoed; tail 1C0 (1'b1,ovf=1,count[6:0]=7'h40; count=64 is 7'b1000000).
//  4. Grant toggling 1,0,0,1,1 over 3 bytes AA BB CC:
//     -> each byte held during low grant; order AA,BB,CC preserved; last flag only on CC.
//  5. Reset asserted in SEND after 1 of 3 bytes -> all outputs 0 next cycle; new frame ADDR,[55] echoes 155 only.
//  6. ECHO_TIMESTAMP_EN, global_counter=8'h2A at frame start, payload 10 -> sl_data 02A,110; tail 102.

Source files
------------

// File: rtl/ice_echo_slave_pkg.sv
// Shared definitions for the ice echo slave: FSM state encoding, the bit
// index of the "last byte" flag on sl_data, and the layout of the tail word.
package ice_echo_slave_pkg;

  // Echo slave FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_DROP,
    ST_REQ,
    ST_SEND,
    ST_TAIL
  } state_e;

  // sl_data[SL_LAST] marks the final byte of a response.
  localparam int SL_LAST = 8;

  // Width of the byte-count field carried in the tail word.
  localparam int TAIL_CNT_W = 7;

  // Tail word: {marker, overflow flag, bytes sent}.
  typedef struct packed {
    logic                  mark;
    logic                  ovf;
    logic [TAIL_CNT_W-1:0] count;
  } tail_t;

endpackage

// File: rtl/ice_echo_buf.sv
// Simple dual-port byte RAM used as the echo payload buffer:
// registered write port, asynchronous read port, 2**DEPTH_LOG2 entries.
module ice_echo_buf #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [7:0]            wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [7:0]            rdata_o
);

  logic [7:0] mem_q [2**DEPTH_LOG2];

  // Write port: store one byte per enabled cycle.
  // NOTE: the storage array has no reset; the slave's count/pointers define
  // which entries are valid, and a reset-free array maps onto RAM primitives.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ice_echo_slave.sv
// ice_echo_slave: captures master frames of type ADDR into a local buffer and
// echoes them back on the slave output bus once the arbiter grants it.
// Optional feature macro: ECHO_TIMESTAMP_EN -- when defined, global_counter
// is sampled at frame start and sent as the first response byte.
module ice_echo_slave
  import ice_echo_slave_pkg::*;
#(
  parameter logic [7:0] ADDR       = 8'h65,
  parameter int         DEPTH_LOG2 = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ma_data,
  input  logic [7:0] ma_addr,
  input  logic       ma_data_valid,
  input  logic       ma_frame_valid,
  output logic       sl_overflow,
  output logic [8:0] sl_addr,
  output logic [8:0] sl_data,
  output logic [8:0] sl_tail,
  output logic       sl_latch_tail,
  output logic       sl_arb_request,
  input  logic       sl_arb_grant,
  input  logic [7:0] global_counter
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;  // payload count width
  localparam int SW    = CW + 1;          // send index width (payload + timestamp)
`ifdef ECHO_TIMESTAMP_EN
  localparam int TS_BYTES = 1;
`else
  localparam int TS_BYTES = 0;
`endif

  state_e                state_q;
  logic [CW-1:0]         count_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [SW-1:0]         snd_q;
  logic                  ovf_q;
  logic                  ovf_pulse_q;
  logic                  fv_q;

  logic                  frame_rise;
  logic                  addr_hit;
  logic                  accept;
  logic                  buf_full;
  logic                  wr_en;
  logic                  drop_byte;
  logic                  sending;
  logic                  pop;
  logic                  last_byte;
  logic                  is_ts_byte;
  logic [SW-1:0]         total;
  logic [7:0]            rd_data;
  logic [7:0]            cur_byte;
  tail_t                 tail_s;

`ifdef ECHO_TIMESTAMP_EN
  logic [7:0] ts_q;

  // Timestamp capture: global_counter at the rise of an accepted frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q <= '0;
    end else if (state_q == ST_IDLE && frame_rise && addr_hit) begin
      ts_q <= global_counter;
    end
  end

  assign is_ts_byte = (snd_q == '0);
  assign cur_byte   = is_ts_byte ? ts_q : rd_data;
`else
  logic unused_global_counter;
  assign unused_global_counter = ^global_counter;
  assign is_ts_byte = 1'b0;
  assign cur_byte   = rd_data;
`endif

  ice_echo_buf #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_buf (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (ma_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // Frame capture decode: which strobes are stored and which are dropped.
  always_comb begin
    frame_rise = ma_frame_valid & ~fv_q;
    addr_hit   = (ma_addr == ADDR);
    accept     = ma_data_valid &
                 (((state_q == ST_IDLE) && frame_rise && addr_hit) ||
                  ((state_q == ST_RECV) && ma_frame_valid));
    buf_full   = (count_q == CW'(DEPTH));
    wr_en      = accept & ~buf_full;
    drop_byte  = accept & buf_full;
  end

  // Response side: byte pop, last-byte flag and gated slave bus outputs.
  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    sending        = (state_q == ST_REQ) || (state_q == ST_SEND);
    pop            = sending & sl_arb_grant;
    total          = SW'(count_q) + SW'(TS_BYTES);
    last_byte      = (snd_q == total - SW'(1));
    sl_arb_request = sending;
    sl_addr        = '0;
    sl_data        = '0;
    if (pop) begin
      sl_addr          = {1'b0, ADDR};
      sl_data[7:0]     = cur_byte;
      sl_data[SL_LAST] = last_byte;
    end
    tail_s.mark    = 1'b1;
    tail_s.ovf     = ovf_q;
    tail_s.count   = TAIL_CNT_W'(total);
    sl_latch_tail  = (state_q == ST_TAIL);
    sl_tail        = sl_latch_tail ? tail_s : '0;
    sl_overflow    = ovf_pulse_q;
  end

  // Main FSM with buffer count, write/read pointers and overflow tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      snd_q       <= '0;
      ovf_q       <= 1'b0;
      ovf_pulse_q <= 1'b0;
      // A frame already in flight at reset release must not look like a rise.
      fv_q        <= 1'b1;
    end else begin
      fv_q        <= ma_frame_valid;
      ovf_pulse_q <= drop_byte;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
        count_q  <= count_q + CW'(1);
      end
      if (drop_byte) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (frame_rise) begin
            state_q <= addr_hit ? ST_RECV : ST_DROP;
          end
        end
        ST_RECV: begin
          if (!ma_frame_valid) begin
            state_q <= (count_q == '0) ? ST_IDLE : ST_REQ;
          end
        end
        ST_DROP: begin
          if (!ma_frame_valid) begin
            state_q <= ST_IDLE;
          end
        end
        ST_REQ, ST_SEND: begin
          if (pop) begin
            snd_q <= snd_q + SW'(1);
            if (!is_ts_byte) begin
              rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
            state_q <= last_byte ? ST_TAIL : ST_SEND;
          end
        end
        ST_TAIL: begin
          state_q  <= ST_IDLE;
          count_q  <= '0;
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          snd_q    <= '0;
          ovf_q    <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
